freq_conv_beep_mc: RTL and testbench



---
 rtl/freq_conv_beep_mc_if.sv | 26 ++
 rtl/freq_conv_beep_mc.sv | 135 +++++++++++++
 tb/tb_freq_conv_beep_mc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_conv_beep_mc_if.sv
// Bus bundle for the multi-channel period counter / tone generator.
// The master drives period, mode, enable and clear; the slave returns count, flags and tones.
interface freq_conv_beep_mc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH    = 4
);
  logic [CH*WIDTH-1:0] cnt_acc;
  logic [CH-1:0]       mode;
  logic [CH-1:0]       cnt_going;
  logic [CH-1:0]       clr;
  logic [CH*WIDTH-1:0] cnt_now;
  logic [CH-1:0]       full_flag;
  logic [CH-1:0]       done;
  logic [CH-1:0]       beep_out;
  logic                beep_mix;

  modport master (
    output cnt_acc, mode, cnt_going, clr,
    input  cnt_now, full_flag, done, beep_out, beep_mix
  );

  modport slave (
    input  cnt_acc, mode, cnt_going, clr,
    output cnt_now, full_flag, done, beep_out, beep_mix
  );
endinterface

// File: rtl/freq_conv_beep_mc.sv
// Multi-channel programmable-period counter with per-channel square-wave tone.
// Each channel runs an independent IDLE/RUN/PAUSE/DONE FSM; only beep_mix is shared.
module freq_conv_beep_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  freq_conv_beep_mc_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  logic [CH-1:0] beep_vec;
  logic          mix_r;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           state, state_nx;
    logic [WIDTH-1:0] acc_r, acc_nx, cnt_r, cnt_nx, acc_in;
    logic             mode_r, mode_nx, full_r, full_nx, done_r, done_nx, beep_r, beep_nx;
    logic             mode_in, going, clr_in, terminal;

    assign acc_in   = bus.cnt_acc[i*WIDTH +: WIDTH];
    assign mode_in  = bus.mode[i];
    assign going    = bus.cnt_going[i];
    assign clr_in   = bus.clr[i];
    assign terminal = (cnt_r == acc_r - WIDTH'(1));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= IDLE;
        acc_r  <= '0;
        mode_r <= 1'b0;
        cnt_r  <= '0;
        full_r <= 1'b0;
        done_r <= 1'b0;
        beep_r <= 1'b0;
      end else begin
        state  <= state_nx;
        acc_r  <= acc_nx;
        mode_r <= mode_nx;
        cnt_r  <= cnt_nx;
        full_r <= full_nx;
        done_r <= done_nx;
        beep_r <= beep_nx;
      end
    end

    // Next state; clear overrides every other transition
    always_comb begin
      state_nx = state;
      if (clr_in) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE:  if (going && acc_in != '0) state_nx = RUN;
          RUN: begin
            if (!going)
              state_nx = PAUSE;
            else if (terminal)
              state_nx = (mode_r && acc_in != '0) ? RUN : DONE;
          end
          PAUSE: if (going) state_nx = RUN;
          DONE:  if (!going) state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end
    end

    // Datapath next values; loop wrap reloads period and mode for glitch-free retune
    always_comb begin
      acc_nx  = acc_r;
      mode_nx = mode_r;
      cnt_nx  = cnt_r;
      full_nx = 1'b0;
      done_nx = done_r;
      beep_nx = beep_r;
      if (clr_in) begin
        cnt_nx  = '0;
        done_nx = 1'b0;
        beep_nx = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt_nx = '0;
            if (going && acc_in != '0) begin
              acc_nx  = acc_in;
              mode_nx = mode_in;
            end
          end
          RUN: begin
            if (going) begin
              if (terminal) begin
                full_nx = 1'b1;
                beep_nx = ~beep_r;
                if (mode_r) begin
                  cnt_nx  = '0;
                  acc_nx  = acc_in;
                  mode_nx = mode_in;
                  if (acc_in == '0) done_nx = 1'b1;
                end else begin
                  done_nx = 1'b1;
                end
              end else begin
                cnt_nx = cnt_r + WIDTH'(1);
              end
            end
          end
          DONE: begin
            if (!going) begin
              cnt_nx  = '0;
              done_nx = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    assign bus.cnt_now[i*WIDTH +: WIDTH] = cnt_r;
    assign bus.full_flag[i]              = full_r;
    assign bus.done[i]                   = done_r;
    assign bus.beep_out[i]               = beep_r;
    assign beep_vec[i]                   = beep_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mix_r <= 1'b0;
    else     mix_r <= |beep_vec;
  end

  assign bus.beep_mix = mix_r;

endmodule

// File: tb/tb_freq_conv_beep_mc.sv
// Bench for freq_conv_beep_mc: behavioural per-channel model checked every cycle,
// plus directed scenarios with hand-derived pulse times and levels.
module tb_freq_conv_beep_mc;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  freq_conv_beep_mc_if #(.WIDTH(W), .CH(N)) ifc ();
  freq_conv_beep_mc #(.WIDTH(W), .CH(N)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a channel is either inactive, counting, holding, or finished
  logic [W-1:0] m_cnt [N];
  logic [W-1:0] m_per [N];
  bit m_loop [N], m_active [N], m_hold [N], m_fin [N];
  bit m_full [N], m_done [N], m_beep [N];
  bit m_mix = 1'b0;
  logic [W-1:0] a_in;

  initial for (int i = 0; i < N; i++) begin
    m_cnt[i] = '0; m_per[i] = '0; m_loop[i] = 0; m_active[i] = 0; m_hold[i] = 0;
    m_fin[i] = 0; m_full[i] = 0; m_done[i] = 0; m_beep[i] = 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mix = 0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = '0; m_per[i] = '0; m_loop[i] = 0; m_active[i] = 0; m_hold[i] = 0;
        m_fin[i] = 0; m_full[i] = 0; m_done[i] = 0; m_beep[i] = 0;
      end
    end else begin
      m_mix = 0;
      for (int i = 0; i < N; i++) m_mix = m_mix | m_beep[i];
      for (int i = 0; i < N; i++) begin
        a_in = ifc.cnt_acc[i*W +: W];
        m_full[i] = 0;
        if (ifc.clr[i]) begin
          m_cnt[i] = '0; m_done[i] = 0; m_beep[i] = 0;
          m_active[i] = 0; m_hold[i] = 0; m_fin[i] = 0;
        end else if (m_fin[i]) begin
          if (!ifc.cnt_going[i]) begin
            m_fin[i] = 0; m_cnt[i] = '0; m_done[i] = 0;
          end
        end else if (!m_active[i]) begin
          if (ifc.cnt_going[i] && a_in != 0) begin
            m_active[i] = 1; m_per[i] = a_in; m_loop[i] = ifc.mode[i]; m_cnt[i] = '0;
          end
        end else if (m_hold[i]) begin
          if (ifc.cnt_going[i]) m_hold[i] = 0;
        end else if (!ifc.cnt_going[i]) begin
          m_hold[i] = 1;
        end else if (longint'(m_cnt[i]) + 1 == longint'(m_per[i])) begin
          m_full[i] = 1;
          m_beep[i] = !m_beep[i];
          if (m_loop[i]) begin
            m_cnt[i] = '0; m_per[i] = a_in; m_loop[i] = ifc.mode[i];
            if (a_in == 0) begin
              m_done[i] = 1; m_fin[i] = 1; m_active[i] = 0;
            end
          end else begin
            m_done[i] = 1; m_fin[i] = 1; m_active[i] = 0;
          end
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("cnt_now[%0d]", i), longint'(ifc.cnt_now[i*W +: W]), longint'(m_cnt[i]));
      check($sformatf("full_flag[%0d]", i), longint'(ifc.full_flag[i]), longint'(m_full[i]));
      check($sformatf("done[%0d]", i), longint'(ifc.done[i]), longint'(m_done[i]));
      check($sformatf("beep_out[%0d]", i), longint'(ifc.beep_out[i]), longint'(m_beep[i]));
    end
    check("beep_mix", longint'(ifc.beep_mix), longint'(m_mix));
  end

  function automatic longint cnt_of(input int ch);
    return longint'(ifc.cnt_now[ch*W +: W]);
  endfunction

  int q[$];
  int k, first_k, pulses, hit;
  bit ok;
  logic [N-1:0] prev_beep;

  initial begin
    ifc.cnt_acc = '0; ifc.mode = '0; ifc.cnt_going = '0; ifc.clr = '0;
    repeat (20) @(negedge clk);
    check("reset cnt_now", longint'(ifc.cnt_now == '0), 1);
    check("reset flags", longint'({ifc.full_flag, ifc.done, ifc.beep_out}), 0);
    rst = 1'b0;

    // Loop mode, period 1000 on ch0
    ifc.cnt_acc[0*W +: W] = 1000; ifc.mode[0] = 1'b1; ifc.cnt_going[0] = 1'b1;
    q.delete(); ok = 1;
    for (k = 1; k <= 12001; k++) begin
      @(negedge clk);
      if (ifc.full_flag[0]) q.push_back(k);
      if (k == 1500 && ifc.beep_out[0] != 1'b1) ok = 0;
      if (k == 2500 && ifc.beep_out[0] != 1'b0) ok = 0;
      if (ifc.done[0]) ok = 0;
    end
    check("t1 pulse count", q.size(), 12);
    check("t1 first pulse", (q.size() > 0) ? q[0] : -1, 1001);
    hit = 1;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 1000) hit = 0;
    check("t1 spacing", hit, 1);
    check("t1 beep/done levels", ok, 1);
    ifc.cnt_going[0] = 1'b0; ifc.clr[0] = 1'b1;
    @(negedge clk); ifc.clr[0] = 1'b0;

    // Single mode, period 600 on ch1
    ifc.cnt_acc[1*W +: W] = 600; ifc.mode[1] = 1'b0; ifc.cnt_going[1] = 1'b1;
    pulses = 0; first_k = -1;
    for (k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (ifc.full_flag[1]) begin pulses++; if (first_k < 0) first_k = k; end
    end
    check("t2 pulse count", pulses, 1);
    check("t2 pulse time", first_k, 601);
    check("t2 held cnt", cnt_of(1), 599);
    check("t2 done", longint'(ifc.done[1]), 1);
    ifc.cnt_going[1] = 1'b0;
    @(negedge clk);
    check("t2 cnt after stop", cnt_of(1), 0);
    check("t2 done after stop", longint'(ifc.done[1]), 0);

    // Pause and resume on ch2
    ifc.cnt_acc[2*W +: W] = 100; ifc.mode[2] = 1'b1; ifc.cnt_going[2] = 1'b1;
    hit = -1;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (cnt_of(2) == 40) begin hit = k; break; end
    end
    check("t3 reach 40", hit, 41);
    ifc.cnt_going[2] = 1'b0; ok = 1;
    for (k = 42; k <= 91; k++) begin
      @(negedge clk);
      if (cnt_of(2) != 40) ok = 0;
    end
    check("t3 hold during pause", ok, 1);
    ifc.cnt_going[2] = 1'b1; hit = -1;
    for (k = 92; k <= 400; k++) begin
      @(negedge clk);
      if (ifc.full_flag[2]) begin hit = k; break; end
    end
    check("t3 resumed pulse time", hit, 152);
    ifc.cnt_going[2] = 1'b0; ifc.clr[2] = 1'b1;
    @(negedge clk); ifc.clr[2] = 1'b0;

    // Retune ch0 from 1000 to 600 mid-period
    ifc.cnt_acc[0*W +: W] = 1000; ifc.mode[0] = 1'b1; ifc.cnt_going[0] = 1'b1;
    q.delete(); hit = -1;
    for (k = 1; k <= 2300; k++) begin
      @(negedge clk);
      if (ifc.full_flag[0]) q.push_back(k);
      if (hit < 0 && cnt_of(0) == 300) begin hit = k; ifc.cnt_acc[0*W +: W] = 600; end
    end
    check("t4 retune point", hit, 301);
    check("t4 pulse count", q.size(), 3);
    check("t4 pulse 0", (q.size() > 0) ? q[0] : -1, 1001);
    check("t4 pulse 1", (q.size() > 1) ? q[1] : -1, 1601);
    check("t4 pulse 2", (q.size() > 2) ? q[2] : -1, 2201);
    ifc.cnt_going[0] = 1'b0; ifc.clr[0] = 1'b1;
    @(negedge clk); ifc.clr[0] = 1'b0;

    // ch3 boundaries: zero period, unit period, clear on terminal edge
    ifc.cnt_acc[3*W +: W] = 0; ifc.mode[3] = 1'b1; ifc.cnt_going[3] = 1'b1; ok = 1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifc.full_flag[3] || cnt_of(3) != 0) ok = 0;
    end
    check("t5 zero period idle", ok, 1);
    ifc.cnt_acc[3*W +: W] = 1; ok = 1;
    for (k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k >= 2 && (ifc.full_flag[3] != 1'b1 || ifc.beep_out[3] != (k % 2 == 0))) ok = 0;
    end
    check("t5 unit period", ok, 1);
    ifc.cnt_going[3] = 1'b0; ifc.clr[3] = 1'b1;
    @(negedge clk);
    ifc.clr[3] = 1'b0; ifc.cnt_acc[3*W +: W] = 5; ifc.cnt_going[3] = 1'b1; hit = -1;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (cnt_of(3) == 4) begin hit = k; break; end
    end
    check("t5 reach terminal", hit, 5);
    ifc.clr[3] = 1'b1;
    @(negedge clk);
    check("t5 clr suppresses flag", longint'(ifc.full_flag[3]), 0);
    check("t5 clr cnt", cnt_of(3), 0);
    ifc.clr[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("t5 restart after clr", cnt_of(3), 1);
    ifc.cnt_going[3] = 1'b0; ifc.clr[3] = 1'b1;
    @(negedge clk); ifc.clr[3] = 1'b0;

    // All channels concurrently, then async reset mid-count
    ifc.clr = '1;
    @(negedge clk);
    ifc.clr = '0;
    ifc.cnt_acc = {32'd11, 32'd7, 32'd5, 32'd3};
    ifc.mode = '1; ifc.cnt_going = '1;
    @(negedge clk);
    prev_beep = ifc.beep_out; ok = 1;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (ifc.beep_mix != |prev_beep) ok = 0;
      prev_beep = ifc.beep_out;
    end
    check("t6 beep_mix lag", ok, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6 async rst cnt_now", longint'(ifc.cnt_now == '0), 1);
    check("t6 async rst flags",
          longint'({ifc.full_flag, ifc.done, ifc.beep_out, ifc.beep_mix}), 0);
    ifc.cnt_going = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
